// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature A/B/Z step generator; index channel (rev_index/out_z) enabled by QGEN_INDEX_EN
module quad_encoder_gen #(
    parameter int POS_W     = 8,
    parameter int DIV_W     = 16,
    parameter int CPR_EDGES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [POS_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic             abort,
    input  logic             zero_pos,
    output logic             out_a,
    output logic             out_b,
    output logic             out_z,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} stateT;

    if (CPR_EDGES < 4 || CPR_EDGES % 4 != 0) begin : gBadCpr
        $error("CPR_EDGES must be a multiple of 4 and >= 4");
    end

    stateT            state, nextState;
    logic             dirReg, edgeDir, accept, tick, finish;
    logic [POS_W-1:0] stepsLeft, stepsRem;
    logic [DIV_W-1:0] period, divCnt, cfgP;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);

    // A P==1 command emits its first edge on the accepting clock; otherwise the divider runs in RUN.
    // After the final edge RUN lingers one cycle so done and cmd_ready appear in separate cycles.
    always_comb begin
        cfgP      = (cfg_period == '0) ? DIV_W'(1) : cfg_period;
        accept    = (state == IDLE) && cmd_valid;
        edgeDir   = (state == IDLE) ? cmd_dir : dirReg;
        stepsRem  = (state == IDLE) ? cmd_steps : stepsLeft;
        tick      = (state == IDLE) ? (accept && cmd_steps != '0 && cfgP == DIV_W'(1))
                  : (stepsLeft != '0 && divCnt == period - DIV_W'(1) && (!abort || stepsLeft == POS_W'(1)));
        finish    = tick && stepsRem == POS_W'(1);
        nextState = (state == IDLE) ? ((accept && cmd_steps != '0) ? RUN : IDLE)
                  : ((stepsLeft == '0 || (abort && !finish)) ? IDLE : RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dirReg    <= 1'b0;
            stepsLeft <= '0;
            period    <= DIV_W'(1);
            divCnt    <= '0;
            out_a     <= 1'b0;
            out_b     <= 1'b0;
            position  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= nextState;
            done      <= finish || (accept && cmd_steps == '0);
            stepsLeft <= tick ? stepsRem - 1'b1 : (accept ? cmd_steps : stepsLeft);
            if (accept) begin
                dirReg <= cmd_dir;
                period <= cfgP;
                divCnt <= (cfgP == DIV_W'(1)) ? '0 : DIV_W'(1);
            end else if (state == RUN) begin
                divCnt <= (divCnt == period - DIV_W'(1)) ? '0 : divCnt + 1'b1;
            end
            if (tick) begin
                out_a <= edgeDir ? out_b : ~out_b;
                out_b <= edgeDir ? ~out_a : out_a;
            end
            position <= zero_pos ? '0 : (tick ? (edgeDir ? position - 1'b1 : position + 1'b1) : position);
        end
    end

`ifdef QGEN_INDEX_EN
    localparam int IDX_W = (CPR_EDGES > 2) ? $clog2(CPR_EDGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CPR_EDGES - 1);

    logic [IDX_W-1:0] revIndex, revNext;

    always_comb
        revNext = edgeDir ? ((revIndex == '0) ? LAST_IDX : revIndex - 1'b1)
                          : ((revIndex == LAST_IDX) ? '0 : revIndex + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            revIndex <= '0;
            out_z    <= 1'b0;
        end else if (tick) begin
            revIndex <= revNext;
            out_z    <= (revNext == '0);
        end
    end
`else
    assign out_z = 1'b0;
`endif
endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb_quad_encoder_gen: directed-vector bench for quad_encoder_gen (POS_W=8, CPR_EDGES=8)
module tb_quad_encoder_gen;
    localparam int POS_W = 8;
    localparam int DIV_W = 16;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0, zero_pos = 1'b0;
    logic [POS_W-1:0] cmd_steps = '0;
    logic [DIV_W-1:0] cfg_period = '0;
    logic             cmd_ready, out_a, out_b, out_z, busy, done;
    logic [POS_W-1:0] position;
    int               nAssert = 0, nFail = 0;
    logic [1:0]       ab1 [9] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    logic             zExp;

    always #5 clk = ~clk;

    quad_encoder_gen #(.POS_W(POS_W), .DIV_W(DIV_W), .CPR_EDGES(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cfg_period(cfg_period),
        .abort(abort), .zero_pos(zero_pos), .out_a(out_a), .out_b(out_b), .out_z(out_z),
        .position(position), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Presents a command in the current cycle T; returns in cycle T+1.
    task automatic send(input logic dir, input logic [POS_W-1:0] steps, input logic [DIV_W-1:0] per);
        cmd_dir = dir; cmd_steps = steps; cfg_period = per; cmd_valid = 1'b1;
        chk("send ready", cmd_ready, 1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst ab", {out_a, out_b}, 2'b00);
        chk("rst z", out_z, 0);
        chk("rst pos", position, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ready", cmd_ready, 1);
        rst_n = 1'b1;
        step(1);

        send(1'b0, 8'd4, 16'd2);
        for (int w = 1; w <= 9; w++) begin
            chk($sformatf("t1 ab@%0d", w), {out_a, out_b}, ab1[w-1]);
            chk($sformatf("t1 done@%0d", w), done, w == 8);
            chk($sformatf("t1 busy@%0d", w), busy, w <= 8);
            if (w < 9) step(1);
        end
        chk("t1 pos", position, 4);
        chk("t1 ready", cmd_ready, 1);

        doReset();
        send(1'b1, 8'd3, 16'd1);
        chk("t2 ab1", {out_a, out_b}, 2'b01);
        step(1);
        chk("t2 ab2", {out_a, out_b}, 2'b11);
        chk("t2 done2", done, 0);
        step(1);
        chk("t2 ab3", {out_a, out_b}, 2'b10);
        chk("t2 done3", done, 1);
        chk("t2 pos", position, 253);
        step(1);
        chk("t2 ready", cmd_ready, 1);
        chk("t2 done off", done, 0);

        send(1'b0, 8'd0, 16'd5);
        chk("t3 done", done, 1);
        chk("t3 busy", busy, 0);
        chk("t3 ab", {out_a, out_b}, 2'b10);
        step(1);
        chk("t3 done off", done, 0);
        chk("t3 busy2", busy, 0);
        chk("t3 pos", position, 253);

        send(1'b0, 8'd2, 16'd0);
        chk("t4 ab1", {out_a, out_b}, 2'b11);
        chk("t4 busy", busy, 1);
        step(1);
        chk("t4 ab2", {out_a, out_b}, 2'b01);
        chk("t4 done", done, 1);
        chk("t4 pos", position, 255);
        step(1);
        chk("t4 ready", cmd_ready, 1);
        send(1'b0, 8'd1, 16'd1);
        chk("wrap ab", {out_a, out_b}, 2'b00);
        chk("wrap pos", position, 0);
        chk("wrap done", done, 1);
        step(1);

        abort = 1'b1;
        send(1'b0, 8'd1, 16'd2);
        chk("fa busy", busy, 1);
        chk("fa ab0", {out_a, out_b}, 2'b00);
        step(1);
        chk("fa ab", {out_a, out_b}, 2'b10);
        chk("fa done", done, 1);
        chk("fa pos", position, 1);
        abort = 1'b0;
        step(1);
        chk("fa ready", cmd_ready, 1);

        doReset();
        send(1'b0, 8'd10, 16'd3);
        step(11);
        chk("ab4 ab", {out_a, out_b}, 2'b00);
        chk("ab4 pos", position, 4);
        chk("ab4 busy", busy, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("ab4 ready", cmd_ready, 1);
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("ab4 hold ab@%0d", w), {out_a, out_b}, 2'b00);
            chk($sformatf("ab4 hold done@%0d", w), done, 0);
            step(1);
        end
        chk("ab4 hold pos", position, 4);

        doReset();
        send(1'b0, 8'd16, 16'd2);
        for (int w = 1; w <= 33; w++) begin
`ifdef QGEN_INDEX_EN
            zExp = (w >= 16 && w < 18) || w >= 32;
`else
            zExp = 1'b0;
`endif
            chk($sformatf("idx z@%0d", w), out_z, zExp);
            if (w == 12) chk("idx zero", position, 0);
            zero_pos = (w == 11);
            step(1);
        end
        zero_pos = 1'b0;
        chk("idx pos", position, 10);
        chk("idx ready", cmd_ready, 1);
        send(1'b1, 8'd1, 16'd1);
        chk("idx rev z", out_z, 0);
        chk("idx rev ab", {out_a, out_b}, 2'b01);
        chk("idx rev pos", position, 9);
        step(1);

        send(1'b0, 8'd10, 16'd1);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst ab", {out_a, out_b}, 2'b00);
        chk("arst pos", position, 0);
        chk("arst busy", busy, 0);
        chk("arst ready", cmd_ready, 1);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
